ex_stage: RTL

Execute stage of the five-stage in-order LoongArch pipeline, at the receiving end of the decode-to-execute bus. It latches one decoded instruction per handshake and computes the ALU result. It issues the data-SRAM request for loads and stores, forwards its destination register back to decode, and passes the result downstream to the memory stage.

---
 rtl/ex_stage_pkg.sv | 47 ++++
 rtl/ex_stage_alu.sv | 42 ++++
 rtl/ex_stage.sv | 67 ++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared pipeline definitions: inter-stage bus widths, ALU opcode bit positions
// and field offsets of the buses leaving the execute stage.
package ex_stage_pkg;

  localparam int unsigned DS_TO_ES_BUS_WD = 148;
  localparam int unsigned ES_TO_MS_BUS_WD = 71;
  localparam int unsigned ES_TO_DS_BUS_WD = 39;
  localparam int unsigned MS_TO_DS_BUS_WD = 38;

  localparam int unsigned ALU_OP_WD = 12;
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  localparam int unsigned ES2MS_PC_LSB           = 0;
  localparam int unsigned ES2MS_RESULT_LSB       = 32;
  localparam int unsigned ES2MS_WADDR_LSB        = 64;
  localparam int unsigned ES2MS_RF_WE_BIT        = 69;
  localparam int unsigned ES2MS_RES_FROM_MEM_BIT = 70;

  localparam int unsigned ES2DS_RESULT_LSB       = 0;
  localparam int unsigned ES2DS_WADDR_LSB        = 32;
  localparam int unsigned ES2DS_RF_WE_BIT        = 37;
  localparam int unsigned ES2DS_RES_FROM_MEM_BIT = 38;

  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 res_from_mem;
    logic [31:0]          alu_src1;
    logic [31:0]          alu_src2;
    logic                 mem_we;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rkd_value;
    logic [31:0]          pc;
  } ds_to_es_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU driven by a one-hot opcode; an all-zero opcode yields 0.
module alu
  import ex_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] alu_op,
  input  logic [31:0]          alu_src1,
  input  logic [31:0]          alu_src2,
  output logic [31:0]          alu_result
);

  logic [31:0]        add_res;
  logic [31:0]        sub_res;
  logic signed [31:0] sra_res;
  logic               slt_res;
  logic               sltu_res;
  logic [4:0]         shamt;

  assign shamt    = alu_src2[4:0];
  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_res = alu_src1 < alu_src2;
  assign sra_res  = $signed(alu_src1) >>> shamt;

  // One-hot opcode lets every unit's output be masked and OR-merged.
  always_comb begin
    alu_result = '0;
    alu_result |= {32{alu_op[ALU_ADD]}}  & add_res;
    alu_result |= {32{alu_op[ALU_SUB]}}  & sub_res;
    alu_result |= {32{alu_op[ALU_SLT]}}  & {31'b0, slt_res};
    alu_result |= {32{alu_op[ALU_SLTU]}} & {31'b0, sltu_res};
    alu_result |= {32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2);
    alu_result |= {32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2);
    alu_result |= {32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2);
    alu_result |= {32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2);
    alu_result |= {32{alu_op[ALU_SLL]}}  & (alu_src1 << shamt);
    alu_result |= {32{alu_op[ALU_SRL]}}  & (alu_src1 >> shamt);
    alu_result |= {32{alu_op[ALU_SRA]}}  & sra_res;
    alu_result |= {32{alu_op[ALU_LUI]}}  & alu_src2;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: holds one decoded instruction, computes its ALU result, issues
// the data-SRAM request and forwards the destination back to decode.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_to_ex_valid,
  output logic                       ex_allowin,
  input  logic [DS_TO_ES_BUS_WD-1:0] id_to_ex_bus,
  input  logic                       mem_allowin,
  output logic                       ex_to_mem_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] ex_to_mem_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] ex_to_id_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  ds_to_es_t   payload;
  logic        ex_valid;
  logic        ex_ready_go;
  logic [31:0] alu_result;
  logic        ex_rf_we;
  logic        ex_res_from_mem;

  assign ex_ready_go     = 1'b1;
  assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
  assign ex_to_mem_valid = ex_valid & ex_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
    end else if (ex_allowin) begin
      ex_valid <= id_to_ex_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      payload <= '0;
    end else if (id_to_ex_valid & ex_allowin) begin
      payload <= ds_to_es_t'(id_to_ex_bus);
    end
  end

  alu u_alu (
    .alu_op     (payload.alu_op),
    .alu_src1   (payload.alu_src1),
    .alu_src2   (payload.alu_src2),
    .alu_result (alu_result)
  );

  assign ex_rf_we        = payload.rf_we & ex_valid;
  assign ex_res_from_mem = payload.res_from_mem & ex_valid;

  // Request only on the hand-off cycle so read data lines up with the memory stage.
  assign data_sram_en    = ex_valid & (payload.res_from_mem | payload.mem_we) & mem_allowin;
  assign data_sram_we    = {4{ex_valid & payload.mem_we & mem_allowin}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = payload.rkd_value;

  assign ex_to_mem_bus = {ex_res_from_mem, ex_rf_we, payload.rf_waddr, alu_result, payload.pc};
  assign ex_to_id_bus  = {ex_res_from_mem, ex_rf_we, payload.rf_waddr, alu_result};

endmodule
